fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests one word at a time from instruction memory,
// holds it in the IR for decode, and follows sequential or branch-redirected flow.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [1:0]  op,
    output logic [5:0]  funct,
    output logic [3:0]  rd,
    output logic [3:0]  cond,
    output logic [31:0] pc_plus8,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        fault
);

    localparam int unsigned CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned PC_W     = 30;
    localparam int unsigned LAST_CNT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t              state;
    logic [PC_W-1:0]     pc_word;
    logic [CNT_W-1:0]    wait_cnt;

    // The PC is kept word-granular so the fetch address is always aligned.
    assign imem_addr = {pc_word, 2'b00};

    // Decode fields are fixed slices of the held IR.
    assign cond  = instr[31:28];
    assign op    = instr[27:26];
    assign funct = instr[25:20];
    assign rd    = instr[15:12];

    // Fetch FSM; all handshake outputs are registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc_word     <= RESET_PC[31:2];
            pc_plus8    <= RESET_PC + 32'd8;
            instr       <= 32'h0;
            wait_cnt    <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end

                REQ: begin
                    // A response on the final allowed cycle still wins over the timeout.
                    if (imem_valid) begin
                        instr       <= imem_rdata;
                        pc_plus8    <= {pc_word, 2'b00} + 32'd8;
                        pc_word     <= pc_word + PC_W'(1);
                        wait_cnt    <= '0;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end else if (wait_cnt == CNT_W'(LAST_CNT)) begin
                        imem_req <= 1'b0;
                        fault    <= 1'b1;
                        state    <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (branch_taken && (branch_target[1:0] != 2'b00)) begin
                            fault <= 1'b1;
                            state <= FAULT;
                        end else begin
                            if (branch_taken) begin
                                pc_word <= branch_target[31:2];
                            end
                            imem_req <= 1'b1;
                            state    <= REQ;
                        end
                    end
                end

                FAULT: begin
                    state <= FAULT;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (reset PC 0 and 0xFFFF_FFFC) share stimulus
// and are compared each cycle against a transaction-level fetch model.
module tb_fetch_unit;

    localparam int unsigned TIMEOUT = 15;
    localparam logic [31:0] RP0 = 32'h0000_0000;
    localparam logic [31:0] RP1 = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_valid = 1'b0;
    logic        instr_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] branch_target = 32'h0;

    logic        req0, iv0, fault0, req1, iv1, fault1;
    logic [31:0] addr0, instr0, pp80, addr1, instr1, pp81;
    logic [1:0]  op0, op1;
    logic [5:0]  funct0, funct1;
    logic [3:0]  rd0, cond0, rd1, cond1;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RP0), .TIMEOUT(TIMEOUT)) dut0 (
        .clk(clk), .reset(reset), .imem_req(req0), .imem_addr(addr0),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid), .instr(instr0),
        .instr_valid(iv0), .instr_ready(instr_ready), .op(op0), .funct(funct0),
        .rd(rd0), .cond(cond0), .pc_plus8(pp80), .branch_taken(branch_taken),
        .branch_target(branch_target), .fault(fault0)
    );

    fetch_unit #(.RESET_PC(RP1), .TIMEOUT(TIMEOUT)) dut1 (
        .clk(clk), .reset(reset), .imem_req(req1), .imem_addr(addr1),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid), .instr(instr1),
        .instr_valid(iv1), .instr_ready(instr_ready), .op(op1), .funct(funct1),
        .rd(rd1), .cond(cond1), .pc_plus8(pp81), .branch_taken(branch_taken),
        .branch_target(branch_target), .fault(fault1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: "started" = past the post-reset idle cycle, "pending" = a read is
    // outstanding, "holding" = a fetched word waits for decode.
    bit          m_started [2];
    bit          m_pending [2];
    bit          m_holding [2];
    bit          m_fault   [2];
    int          m_misses  [2];
    logic [31:0] m_pc      [2];
    logic [31:0] m_ir      [2];
    logic [31:0] m_ipc     [2];

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_started[i] = 0;
            m_pending[i] = 0;
            m_holding[i] = 0;
            m_fault[i]   = 0;
            m_misses[i]  = 0;
            m_pc[i]      = (i == 0) ? RP0 : RP1;
            m_ipc[i]     = m_pc[i];
            m_ir[i]      = 32'h0;
        end
    endfunction

    function automatic void model_edge();
        for (int i = 0; i < 2; i++) begin
            if (m_fault[i]) begin
                // sticky until reset
            end else if (!m_started[i]) begin
                m_started[i] = 1;
                m_pending[i] = 1;
            end else if (m_pending[i]) begin
                if (imem_valid) begin
                    m_ir[i]      = imem_rdata;
                    m_ipc[i]     = m_pc[i];
                    m_pc[i]      = m_pc[i] + 32'd4;
                    m_pending[i] = 0;
                    m_holding[i] = 1;
                    m_misses[i]  = 0;
                end else begin
                    m_misses[i]++;
                    if (m_misses[i] == int'(TIMEOUT)) begin
                        m_fault[i]   = 1;
                        m_pending[i] = 0;
                    end
                end
            end else if (m_holding[i] && instr_ready) begin
                m_holding[i] = 0;
                if (branch_taken && (branch_target % 4) != 0) begin
                    m_fault[i] = 1;
                end else begin
                    if (branch_taken) m_pc[i] = branch_target;
                    m_pending[i] = 1;
                end
            end
        end
    endfunction

    task automatic check_dut(input int i, input logic req, input logic [31:0] addr,
                             input logic [31:0] ir, input logic iv, input logic [1:0] o,
                             input logic [5:0] f, input logic [3:0] r, input logic [3:0] c,
                             input logic [31:0] pp8, input logic flt);
        check($sformatf("dut%0d.imem_req", i), req, m_pending[i]);
        if (m_pending[i]) check($sformatf("dut%0d.imem_addr", i), addr, m_pc[i]);
        check($sformatf("dut%0d.instr", i), ir, m_ir[i]);
        check($sformatf("dut%0d.instr_valid", i), iv, m_holding[i]);
        check($sformatf("dut%0d.op", i), o, (m_ir[i] >> 26) % 4);
        check($sformatf("dut%0d.funct", i), f, (m_ir[i] >> 20) % 64);
        check($sformatf("dut%0d.rd", i), r, (m_ir[i] >> 12) % 16);
        check($sformatf("dut%0d.cond", i), c, m_ir[i] >> 28);
        check($sformatf("dut%0d.pc_plus8", i), pp8, m_ipc[i] + 32'd8);
        check($sformatf("dut%0d.fault", i), flt, m_fault[i]);
    endtask

    task automatic check_all();
        check_dut(0, req0, addr0, instr0, iv0, op0, funct0, rd0, cond0, pp80, fault0);
        check_dut(1, req1, addr1, instr1, iv1, op1, funct1, rd1, cond1, pp81, fault1);
    endtask

    // One clock: drive at negedge, model at posedge, compare at the next negedge.
    task automatic step(input logic v, input logic [31:0] d, input logic rdy,
                        input logic bt, input logic [31:0] tg);
        imem_valid    = v;
        imem_rdata    = d;
        instr_ready   = rdy;
        branch_taken  = bt;
        branch_target = tg;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_async.imem_req0", req0, 1'b0);
        check("rst_async.imem_req1", req1, 1'b0);
        check("rst_async.instr_valid0", iv0, 1'b0);
        check("rst_async.fault0", fault0, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        check_all();
    endtask

    int pv;
    logic v;
    logic [31:0] tg;

    initial begin
        @(negedge clk);
        do_reset();

        // First request after the idle cycle, then a simple fetch one cycle later.
        step(0, 32'h0, 0, 0, 32'h0);
        check("first_req", req0, 1'b1);
        check("first_addr1", addr1, 32'hFFFF_FFFC);
        step(1, 32'hE281_1001, 0, 0, 32'h0);
        check("ir", instr0, 32'hE281_1001);
        check("cond", cond0, 32'hE);
        check("op", op0, 32'h0);
        check("funct", funct0, 32'h28);
        check("rd", rd0, 32'h1);
        check("pc_plus8", pp80, 32'h8);
        check("wrap_pc_plus8", pp81, 32'h4);

        // Decode stalls; a branch without ready must not redirect.
        for (int k = 0; k < 5; k++) step(1, $urandom, 0, 1, 32'h200);
        check("stall_ir", instr0, 32'hE281_1001);
        check("stall_iv", iv0, 1'b1);
        step(0, 32'h0, 1, 0, 32'h0);
        check("seq_addr", addr0, 32'h4);
        check("wrap_addr", addr1, 32'h0);

        // Taken branch to an aligned target.
        step(1, 32'h1111_1111, 0, 0, 32'h0);
        step(0, 32'h0, 1, 1, 32'h100);
        check("branch_addr", addr0, 32'h100);

        // Valid on the last allowed cycle is accepted.
        for (int k = 0; k < int'(TIMEOUT) - 1; k++) step(0, 32'h0, 0, 0, 32'h0);
        step(1, 32'hABCD_0123, 0, 0, 32'h0);
        check("late_valid_iv", iv0, 1'b1);
        check("late_valid_fault", fault0, 1'b0);

        // Full timeout faults, and the fault is sticky.
        step(0, 32'h0, 1, 0, 32'h0);
        for (int k = 0; k < int'(TIMEOUT); k++) step(0, 32'h0, 0, 0, 32'h0);
        check("timeout_fault", fault0, 1'b1);
        for (int k = 0; k < 3; k++) step(1, $urandom, 1, 1, 32'h40);
        check("timeout_sticky_req", req0, 1'b0);

        // Misaligned branch target.
        do_reset();
        step(0, 32'h0, 0, 0, 32'h0);
        step(1, 32'h0000_F000, 0, 0, 32'h0);
        step(0, 32'h0, 1, 1, 32'h102);
        check("misaligned_fault", fault0, 1'b1);

        // Reset in the middle of an outstanding request.
        do_reset();
        step(0, 32'h0, 0, 0, 32'h0);
        step(0, 32'h0, 0, 0, 32'h0);
        do_reset();
        step(1, 32'h5555_5555, 0, 0, 32'h0);
        check("refetch_iv", iv0, 1'b0);
        check("refetch_addr", addr0, RP0);
        step(1, 32'h1234_5678, 0, 0, 32'h0);
        check("refetch_ir", instr0, 32'h1234_5678);

        // Randomized traffic with varying memory responsiveness.
        pv = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 100 == 0) pv = $urandom_range(0, 2) == 0 ? 8 : ($urandom_range(0, 1) == 0 ? 50 : 90);
            if ($urandom_range(0, 299) == 0 || (m_fault[0] && $urandom_range(0, 9) == 0)) begin
                do_reset();
            end else begin
                v  = ($urandom_range(0, 99) < pv);
                tg = $urandom;
                if ($urandom_range(0, 4) != 0) tg[1:0] = 2'b00;
                step(v, $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, tg);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
